// File: rtl/s8_jk_stim.sv
// s8_jk_stim: synchronises and debounces board switches/keys for the JK flip-flop stage,
// and turns each accepted KEY_CP press into one fixed-width CP pulse with a press counter.

module s8_jk_stim_db #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned CNT_W     = 20,
    parameter logic        IDLE_LVL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic stable
);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Two-flop synchroniser, stable level and debounce counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= IDLE_LVL;
            sync2_q  <= IDLE_LVL;
            stable_q <= IDLE_LVL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Accept the new level only after DB_CYCLES consecutive mismatching samples
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign stable = stable_q;

endmodule

module s8_jk_stim #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned PULSE_W   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SW_J,
    input  logic       SW_K,
    input  logic       KEY_CP,
    input  logic       KEY_S,
    input  logic       KEY_R,
    output logic       J,
    output logic       K,
    output logic       CP,
    output logic       S,
    output logic       R,
    output logic [7:0] CP_CNT
);

    localparam int unsigned PCNT_W = 8;
    localparam int unsigned CCNT_W = 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PULSE    = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;

    logic sw_j_st;
    logic sw_k_st;
    logic key_cp_st;
    logic key_s_st;
    logic key_r_st;

    s8_jk_stim_db #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .IDLE_LVL(1'b0)) u_db_j (
        .clk(CLK), .rst_n(RESET), .din(SW_J), .stable(sw_j_st)
    );
    s8_jk_stim_db #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .IDLE_LVL(1'b0)) u_db_k (
        .clk(CLK), .rst_n(RESET), .din(SW_K), .stable(sw_k_st)
    );
    s8_jk_stim_db #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .IDLE_LVL(1'b1)) u_db_cp (
        .clk(CLK), .rst_n(RESET), .din(KEY_CP), .stable(key_cp_st)
    );
    s8_jk_stim_db #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .IDLE_LVL(1'b1)) u_db_s (
        .clk(CLK), .rst_n(RESET), .din(KEY_S), .stable(key_s_st)
    );
    s8_jk_stim_db #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .IDLE_LVL(1'b1)) u_db_r (
        .clk(CLK), .rst_n(RESET), .din(KEY_R), .stable(key_r_st)
    );

    logic [3:0]        lvl_q;
    logic [3:0]        lvl_d;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [PCNT_W-1:0] pcnt_q;
    logic [PCNT_W-1:0] pcnt_d;
    logic              cp_q;
    logic              cp_d;
    logic [CCNT_W-1:0] cp_cnt_q;
    logic [CCNT_W-1:0] cp_cnt_d;
    logic              press_prev_q;
    logic              press_c;

    assign press_c = ~key_cp_st;

    // Level outputs: {R, S, K, J}, keys inverted to active-high; no S/R interlock
    always_comb begin
        lvl_d = {~key_r_st, ~key_s_st, sw_k_st, sw_j_st};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lvl_q        <= '0;
            state_q      <= ST_IDLE;
            pcnt_q       <= '0;
            cp_q         <= 1'b0;
            cp_cnt_q     <= '0;
            press_prev_q <= 1'b0;
        end else begin
            lvl_q        <= lvl_d;
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            cp_q         <= cp_d;
            cp_cnt_q     <= cp_cnt_d;
            press_prev_q <= press_c;
        end
    end

    // One CP pulse per debounced press; a held key must be released before the next one
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        cp_d     = cp_q;
        cp_cnt_d = cp_cnt_q;
        case (state_q)
            ST_IDLE: begin
                cp_d = 1'b0;
                if (press_c && !press_prev_q) begin
                    pcnt_d   = PCNT_W'(PULSE_W - 1);
                    cp_d     = 1'b1;
                    cp_cnt_d = cp_cnt_q + CCNT_W'(1);
                    state_d  = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (pcnt_q == '0) begin
                    cp_d    = 1'b0;
                    state_d = ST_WAIT_REL;
                end else begin
                    cp_d   = 1'b1;
                    pcnt_d = pcnt_q - PCNT_W'(1);
                end
            end
            ST_WAIT_REL: begin
                cp_d = 1'b0;
                if (!press_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cp_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign J      = lvl_q[0];
    assign K      = lvl_q[1];
    assign S      = lvl_q[2];
    assign R      = lvl_q[3];
    assign CP     = cp_q;
    assign CP_CNT = cp_cnt_q;

endmodule

// File: tb/tb_s8_jk_stim.sv
// Bench for s8_jk_stim: window-based debounce/pulse model checked every cycle, plus literal timing pins.

module tb_s8_jk_stim;

    localparam int DB = 4;
    localparam int PW = 3;
    localparam logic [4:0] IDLE = 5'b11100;  // {R,S,CP,K,J} raw idle levels

    logic       CLK;
    logic       RESET;
    logic       SW_J, SW_K, KEY_CP, KEY_S, KEY_R;
    logic       J, K, CP, S, R;
    logic [7:0] CP_CNT;

    int total = 0;
    int bad   = 0;

    s8_jk_stim #(.DB_CYCLES(DB), .CNT_W(4), .PULSE_W(PW)) dut (
        .CLK(CLK), .RESET(RESET),
        .SW_J(SW_J), .SW_K(SW_K), .KEY_CP(KEY_CP), .KEY_S(KEY_S), .KEY_R(KEY_R),
        .J(J), .K(K), .CP(CP), .S(S), .R(R), .CP_CNT(CP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [4:0] mh [DB+2];  // raw samples, index 0 = newest
    logic [4:0] m_stable = IDLE;
    logic       m_press_prev = 1'b0;
    int         m_cp_rem = 0;
    logic [7:0] m_cnt = 8'd0;
    logic       m_all;
    logic       m_press;
    logic       e_j = 0, e_k = 0, e_cp = 0, e_s = 0, e_r = 0;
    logic [7:0] e_cnt = 8'd0;

    task automatic model_reset();
        for (int i = 0; i < DB + 2; i++) mh[i] = IDLE;
        m_stable = IDLE; m_press_prev = 1'b0; m_cp_rem = 0; m_cnt = 8'd0;
        e_j = 0; e_k = 0; e_cp = 0; e_s = 0; e_r = 0; e_cnt = 8'd0;
    endtask

    task automatic model_step();
        e_j = m_stable[0];
        e_k = m_stable[1];
        e_s = ~m_stable[3];
        e_r = ~m_stable[4];
        m_press = ~m_stable[2];
        if (m_cp_rem > 0) m_cp_rem--;
        if (m_press && !m_press_prev) begin
            m_cp_rem = PW;
            m_cnt    = m_cnt + 8'd1;
        end
        m_press_prev = m_press;
        e_cp  = (m_cp_rem > 0);
        e_cnt = m_cnt;
        for (int i = DB + 1; i > 0; i--) mh[i] = mh[i-1];
        mh[0] = {KEY_R, KEY_S, KEY_CP, SW_K, SW_J};
        // a level is accepted once DB delayed samples in a row all disagree with it
        for (int b = 0; b < 5; b++) begin
            m_all = 1'b1;
            for (int k = 3; k <= DB + 1; k++) if (mh[k][b] != mh[2][b]) m_all = 1'b0;
            if (m_all && (mh[2][b] != m_stable[b])) m_stable[b] = mh[2][b];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RESET);
            if (!RESET) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            check("J",      int'(J),      int'(e_j));
            check("K",      int'(K),      int'(e_k));
            check("CP",     int'(CP),     int'(e_cp));
            check("S",      int'(S),      int'(e_s));
            check("R",      int'(R),      int'(e_r));
            check("CP_CNT", int'(CP_CNT), int'(e_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic nclk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic idle_inputs();
        SW_J = 0; SW_K = 0; KEY_CP = 1; KEY_S = 1; KEY_R = 1;
    endtask

    int   first, rises, width, seen;
    logic prev_cp;
    int   hold [5];
    logic [4:0] rv;

    // Watch n cycles, recording first CP rise (1-based) and CP-high count
    task automatic watch_cp(input int n);
        for (int i = 1; i <= n; i++) begin
            nclk(1);
            if (CP && !prev_cp) begin
                rises++;
                if (first < 0) first = i;
            end
            if (CP) width++;
            prev_cp = CP;
        end
    endtask

    initial begin
        RESET = 0;
        idle_inputs();

        // reset held with inputs toggling
        for (int i = 0; i < 10; i++) begin
            nclk(1);
            {KEY_R, KEY_S, KEY_CP, SW_K, SW_J} = 5'($urandom);
        end
        nclk(1);
        check("rst_cp",  int'(CP), 0);
        check("rst_cnt", int'(CP_CNT), 0);
        check("rst_lvl", int'({J, K, S, R}), 0);
        idle_inputs();
        nclk(1);
        RESET = 1;
        nclk(10);
        check("post_rst_out", int'({J, K, CP, S, R, CP_CNT}), 0);

        // debounce reject: 3-clock glitch
        SW_J = 1;
        nclk(3);
        SW_J = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            nclk(1);
            if (J) seen = 1;
        end
        check("glitch_j", seen, 0);

        // debounce accept: J rises on the 7th edge
        SW_J = 1;
        nclk(6);
        check("j_edge6", int'(J), 0);
        nclk(1);
        check("j_edge7", int'(J), 1);
        nclk(3);
        SW_J = 0;
        nclk(10);

        // single held press
        KEY_CP = 0;
        first = -1; rises = 0; width = 0; prev_cp = CP;
        for (int i = 1; i <= 20; i++) begin
            nclk(1);
            if (CP && !prev_cp) begin rises++; if (first < 0) first = i; end
            if (CP) width++;
            prev_cp = CP;
            if (i == 6) check("cnt_before", int'(CP_CNT), 0);
            if (i == 7) check("cnt_at_rise", int'(CP_CNT), 1);
        end
        check("press_rises", rises, 1);
        check("press_first", first, 7);
        check("press_width", width, 3);
        KEY_CP = 1;
        nclk(10);

        // bouncing press
        KEY_CP = 0; nclk(1);
        KEY_CP = 1; nclk(1);
        KEY_CP = 0; nclk(1);
        KEY_CP = 1; nclk(1);
        KEY_CP = 0;
        first = -1; rises = 0; width = 0; prev_cp = CP;
        watch_cp(10);
        KEY_CP = 1;
        watch_cp(10);
        check("bounce_rises", rises, 1);
        check("bounce_first", first, 7);
        check("bounce_cnt", int'(CP_CNT), 2);

        // counter wrap from a fresh reset
        RESET = 0;
        nclk(2);
        RESET = 1;
        nclk(2);
        for (int p = 0; p < 256; p++) begin
            KEY_CP = 0; nclk(8);
            KEY_CP = 1; nclk(8);
            if (p == 254) check("cnt_255", int'(CP_CNT), 255);
        end
        check("cnt_wrap", int'(CP_CNT), 0);

        // S and R together, CP untouched
        KEY_S = 0; KEY_R = 0;
        seen = 0;
        for (int i = 1; i <= 10; i++) begin
            nclk(1);
            if (CP) seen = 1;
            if (i == 6) check("sr_edge6", int'({S, R}), 0);
            if (i == 7) check("sr_edge7", int'({S, R}), 3);
        end
        check("sr_no_cp", seen, 0);
        KEY_S = 1; KEY_R = 1;
        nclk(10);

        // reset mid-pulse, key still held
        KEY_CP = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            nclk(1);
            if (CP) seen = 1;
        end
        check("mid_cp_seen", seen, 1);
        nclk(1);
        RESET = 0;
        #1;
        check("mid_rst_cp",  int'(CP), 0);
        check("mid_rst_cnt", int'(CP_CNT), 0);
        nclk(1);
        RESET = 1;
        first = -1; rises = 0; width = 0; prev_cp = CP;
        watch_cp(10);
        check("mid_new_first", first, 7);
        check("mid_new_cnt", int'(CP_CNT), 1);
        KEY_CP = 1;
        nclk(12);

        // random phase against the model
        for (int b = 0; b < 5; b++) hold[b] = 0;
        rv = IDLE;
        for (int c = 0; c < 2000; c++) begin
            nclk(1);
            RESET = ($urandom_range(0, 299) != 0);
            for (int b = 0; b < 5; b++) begin
                if (hold[b] == 0) begin
                    rv[b]   = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 9);
                end else begin
                    hold[b]--;
                end
            end
            {KEY_R, KEY_S, KEY_CP, SW_K, SW_J} = rv;
        end
        nclk(1);
        RESET = 1;
        idle_inputs();
        nclk(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
